varredura_display: RTL and testbench
====================================

# varredura_display

Time-multiplexed scan controller that shares one 7-segment decoder across N_DIG common-anode digits. It sequences digit selection with a programmable on-time and a blanking dead-time between digits to prevent ghosting. A shadow-buffered value is accepted through a valid/ready handshake and becomes visible only at frame boundaries. It sits between the ULA result/operand registers and the board display pins.

## Interface
- N_DIG, 4, number of digits scanned; must be ≥ 1.
- DIG_CYCLES, 50000, clock cycles each digit is lit; must be ≥ 1.
- DEAD_CYCLES, 500, all-off cycles between digits; must be ≥ 1.

- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- en  in  1  scan enable; low forces the display dark.
- wr_valid  in  1  new display value offered.
- wr_data  in  4*N_DIG  hex nibbles; nibble i is bits [4i+3:4i]; digit 0 is least significant.
- wr_ready  out  1  high when no pending value is held.
- blank  in  N_DIG  per-digit force-off mask, sampled live.
- SEG  out  7  active-low segments a..g on SEG[0]..SEG[6], registered.
- AN  out  N_DIG  active-low digit enables, registered, at most one low.
- frame_done  out  1  one-cycle pulse when the last digit's dead-time ends.

## Operation
- FSM states: OFF, SHOW, DEAD.
- Reset values:
  - State OFF; digit index 0; prescaler 0.
  - Shadow register 0; pending register empty.
  - SEG = 7'h7F, AN = all ones, frame_done = 0, wr_ready = 1.
- OFF:
  - AN all ones, SEG 7'h7F; index and prescaler held at 0.
  - When en=1, move to SHOW with index 0 on the next edge.
- SHOW:
  - AN[index]=0 unless blank[index]=1, in which case AN is all ones for the slot.
  - SEG = decode(shadow nibble[index]).
  - After DIG_CYCLES cycles, move to DEAD.
- DEAD:
  - AN all ones, SEG 7'h7F for DEAD_CYCLES cycles, then go to SHOW with index+1.
  - When index = N_DIG-1, wrap to 0, pulse frame_done, and commit the pending value into shadow if one is held.
- en low in any state: OFF on the next edge, counters cleared. Shadow and pending are kept.
- Handshake:
  - Transfer occurs when wr_valid & wr_ready on an edge: wr_data goes into pending and wr_ready drops.
  - wr_ready returns to 1 the cycle after commit.
  - In OFF, a held pending value commits on the next edge.
  - A transfer in the same cycle as a frame boundary while wr_ready=1 is stored as pending and commits at the following boundary.
- Reset mid-scan overrides everything: all state returns to reset values and a held pending value is discarded.

## Timing
- Registered outputs: SEG and AN reflect the FSM state one cycle later and always change on the same edge.
- Frame period in steady state: N_DIG*(DIG_CYCLES+DEAD_CYCLES) cycles.
- en rise to first AN low: 2 cycles (OFF→SHOW edge, then the output register).
- Prescaler width: $clog2 of the larger of DIG_CYCLES and DEAD_CYCLES, plus 1. It counts 0..limit-1 and wraps to 0 on each state change.
- Latency from accepted write to visible digits: up to one frame plus 1 cycle.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digits above the most significant nonzero nibble of shadow are treated as blank=1.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
- Undefined: all digits show their nibble, including leading zeros; only the blank input suppresses digits.

## Structure
- Shared package varredura_pkg holds:
  - the state encoding constants (OFF, SHOW, DEAD);
  - SEG_OFF = 7'h7F.
- One sub-module: the existing decodificador_7seg, instantiated once and fed by the nibble mux. Its output goes into the SEG register.
- The prescaler, index counter, FSM, and pending/shadow registers stay in this module.

## Test plan
Benches use N_DIG=4, DIG_CYCLES=4, DEAD_CYCLES=2.
- Scan order: reset, then en=1 and write 16'h1234 → AN sequence 1110, 1101, 1011, 0111, each 4 cycles with 2 cycles of 1111 between; SEG = 7'h79, 7'h24, 7'h30, 7'h19 (active-low codes for 1, 2, 3, 4); frame_done pulses every 24 cycles.
- Deferred update: write 16'hABCD mid-frame → wr_ready=0 until the boundary; digits still show 1234 until frame_done, then show D, C, b, A.
- Blank mask: blank=4'b0100 → AN never equals 1011; the slot timing of the other digits is unchanged.
- Enable and reset: en=0 mid-SHOW → next cycle state OFF, and AN=1111, SEG=7F one cycle later; reset mid-frame with a pending value → wr_ready=1 and shadow=0.
- Simultaneous write and boundary: wr_valid asserted on the frame_done cycle → value visible only after the next frame_done.
- Configuration with LEADING_ZERO_BLANK_EN: write 16'h0005 → only digit 0 is lit; write 16'h0000 → digit 0 shows 7'h40.

Source files
------------

// File: rtl/varredura_display_pkg.sv
// varredura_pkg: shared definitions for the varredura_display scan controller.
//   state_t : scan FSM states (OFF, SHOW, DEAD)
//   SEG_OFF : active-low segment pattern with every segment dark
package varredura_pkg;

   typedef enum logic [1:0] {
      OFF,
      SHOW,
      DEAD
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/varredura_display_decodificador_7seg.sv
// decodificador_7seg: hex nibble to active-low 7-segment pattern.
//   nibble : input hex digit 0..F
//   seg    : active-low segments, a..g on seg[0]..seg[6] (lowercase b and d)
module decodificador_7seg (
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      unique case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/varredura_display.sv
// varredura_display: time-multiplexed scan of N_DIG common-anode digits
// sharing one 7-segment decoder, with blanking dead-time between digits and
// a shadow-buffered display value committed at frame boundaries.
//   clk, reset      : clock, synchronous active-high reset
//   en              : scan enable (low = display dark, FSM in OFF)
//   wr_valid/ready  : handshake for wr_data (4*N_DIG bits, nibble 0 = digit 0)
//   blank           : live per-digit force-off mask
//   SEG             : registered active-low segments a..g on SEG[0]..SEG[6]
//   AN              : registered active-low digit enables
//   frame_done      : one-cycle pulse after the last digit's dead-time
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module varredura_display
   import varredura_pkg::*;
#(
   parameter int N_DIG       = 4,
   parameter int DIG_CYCLES  = 50000,
   parameter int DEAD_CYCLES = 500
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               wr_valid,
   input  logic [4*N_DIG-1:0] wr_data,
   output logic               wr_ready,
   input  logic [N_DIG-1:0]   blank,
   output logic [6:0]         SEG,
   output logic [N_DIG-1:0]   AN,
   output logic               frame_done
);

   localparam int MAX_CYC = (DIG_CYCLES > DEAD_CYCLES) ? DIG_CYCLES : DEAD_CYCLES;
   localparam int PW      = $clog2(MAX_CYC) + 1;
   localparam int IW      = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   localparam logic [PW-1:0] DIG_LAST  = PW'(DIG_CYCLES - 1);
   localparam logic [PW-1:0] DEAD_LAST = PW'(DEAD_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);

   state_t               state_q, state_d;
   logic [PW-1:0]        presc_q, presc_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic                 boundary;

   logic [4*N_DIG-1:0]   shadow_q;
   logic [4*N_DIG-1:0]   pend_data_q;
   logic                 pend_q;
   logic                 commit;

   logic [3:0]           nibble;
   logic [6:0]           seg_dec;
   logic [N_DIG-1:0]     lz_mask;
   logic                 suppress;
   logic [6:0]           seg_d;
   logic [N_DIG-1:0]     an_d;

   assign wr_ready = ~pend_q;
   assign nibble   = shadow_q[{idx_q, 2'b00} +: 4];

   decodificador_7seg u_dec (
      .nibble (nibble),
      .seg    (seg_dec)
   );

`ifdef LEADING_ZERO_BLANK_EN
   // Walk down from the top digit; everything above the first nonzero
   // nibble is suppressed. Digit 0 is never part of the walk.
   always_comb begin
      logic found;
      lz_mask = '0;
      found   = 1'b0;
      for (int unsigned i = N_DIG - 1; i >= 1; i--) begin
         if (!found) begin
            if (shadow_q[4*i +: 4] != 4'h0) found = 1'b1;
            else                            lz_mask[i] = 1'b1;
         end
      end
   end
`else
   assign lz_mask = '0;
`endif

   assign suppress = blank[idx_q] | lz_mask[idx_q];

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      idx_d    = idx_q;
      boundary = 1'b0;

      if (!en) begin
         state_d = OFF;
         presc_d = '0;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            OFF: begin
               state_d = SHOW;
               presc_d = '0;
               idx_d   = '0;
            end
            SHOW: begin
               if (presc_q == DIG_LAST) begin
                  state_d = DEAD;
                  presc_d = '0;
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            DEAD: begin
               if (presc_q == DEAD_LAST) begin
                  state_d = SHOW;
                  presc_d = '0;
                  if (idx_q == IDX_LAST) begin
                     idx_d    = '0;
                     boundary = 1'b1;
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end else begin
                  presc_d = presc_q + PW'(1);
               end
            end
            default: begin
               state_d = OFF;
               presc_d = '0;
               idx_d   = '0;
            end
         endcase
      end

      // Outputs follow the current state; the output register adds the lag
      an_d  = '1;
      seg_d = SEG_OFF;
      if (state_q == SHOW) begin
         seg_d = seg_dec;
         if (!suppress) an_d[idx_q] = 1'b0;
      end
   end

   // A pending value is committed at a frame boundary, or at once while OFF
   assign commit = pend_q & (boundary | (state_q == OFF));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= OFF;
         presc_q     <= '0;
         idx_q       <= '0;
         shadow_q    <= '0;
         pend_data_q <= '0;
         pend_q      <= 1'b0;
         SEG         <= SEG_OFF;
         AN          <= '1;
         frame_done  <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         SEG        <= seg_d;
         AN         <= an_d;
         frame_done <= boundary;
         if (commit) begin
            shadow_q <= pend_data_q;
            pend_q   <= 1'b0;
         end else if (wr_valid && !pend_q) begin
            pend_data_q <= wr_data;
            pend_q      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_varredura_display.sv
module tb_varredura_display;

   localparam int N  = 4;
   localparam int DC = 4;
   localparam int DD = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic          wr_valid;
   logic [15:0]   wr_data;
   logic          wr_ready;
   logic [3:0]    blank;
   logic [6:0]    seg;
   logic [3:0]    an;
   logic          frame_done;

   int            checks   = 0;
   int            failures = 0;
   logic [11:0]   exp_q[$];

   always #5 clk = ~clk;

   varredura_display #(
      .N_DIG       (N),
      .DIG_CYCLES  (DC),
      .DEAD_CYCLES (DD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .wr_valid   (wr_valid),
      .wr_data    (wr_data),
      .wr_ready   (wr_ready),
      .blank      (blank),
      .SEG        (seg),
      .AN         (an),
      .frame_done (frame_done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;
         4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;
         4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;
         4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;
         4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // One frame of expected {AN, SEG, frame_done} per output cycle
   task automatic push_frame(input logic [15:0] val, input logic [3:0] blk);
      logic [3:0] vis;
      logic [3:0] an_e;
      int         top;
      vis = ~blk;
      top = 0;
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 0; i < N; i++) if (val[4*i +: 4] != 4'h0) top = i;
      for (int i = 1; i < N; i++) if (i > top) vis[i] = 1'b0;
`endif
      for (int d = 0; d < N; d++) begin
         an_e = 4'hF;
         if (vis[d]) an_e[d] = 1'b0;
         for (int c = 0; c < DC; c++) exp_q.push_back({an_e, seg_of(val[4*d +: 4]), 1'b0});
         for (int c = 0; c < DD; c++)
            exp_q.push_back({4'hF, 7'h7F, (d == N-1 && c == DD-1)});
      end
   endtask

   task automatic push_dark(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({4'hF, 7'h7F, 1'b0});
   endtask

   task automatic run(input int n);
      logic [11:0] e;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("scan", 32'({an, seg, frame_done}), 32'(e));
         end
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_data = '0; blank = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_an",    32'(an),         32'hF);
      check("rst_seg",   32'(seg),        32'h7F);
      check("rst_fd",    32'(frame_done), 32'h0);
      check("rst_ready", 32'(wr_ready),   32'h1);

      // load 1234 while OFF: pending, then committed on the next edge
      wr_valid = 1'b1; wr_data = 16'h1234;
      @(negedge clk);
      wr_valid = 1'b0;
      check("ready_after_wr", 32'(wr_ready), 32'h0);
      @(negedge clk);
      check("ready_off_commit", 32'(wr_ready), 32'h1);

      // scan order: 2-cycle latency from en to first lit digit
      en = 1'b1;
      push_dark(1);
      push_frame(16'h1234, 4'h0);
      push_frame(16'h1234, 4'h0);
      run(49);

      // deferred update: write mid-frame, visible after frame_done
      push_frame(16'h1234, 4'h0);
      run(10);
      wr_valid = 1'b1; wr_data = 16'hABCD;
      run(1);
      wr_valid = 1'b0;
      check("ready_pending", 32'(wr_ready), 32'h0);
      run(12);
      check("ready_held", 32'(wr_ready), 32'h0);
      run(1);
      check("ready_after_commit", 32'(wr_ready), 32'h1);
      push_frame(16'hABCD, 4'h0);
      run(24);

      // blank mask on digit 2
      blank = 4'b0100;
      push_frame(16'hABCD, 4'b0100);
      run(24);
      blank = 4'b0000;

      // write on the boundary cycle: held one extra frame
      push_frame(16'hABCD, 4'h0);
      run(23);
      wr_valid = 1'b1; wr_data = 16'h5678;
      check("ready_at_boundary", 32'(wr_ready), 32'h1);
      run(1);
      wr_valid = 1'b0;
      check("ready_boundary_wr", 32'(wr_ready), 32'h0);
      push_frame(16'hABCD, 4'h0);
      run(24);
      check("ready_boundary_commit", 32'(wr_ready), 32'h1);

      // en low mid-SHOW: dark one cycle after the state goes OFF
      push_frame(16'h5678, 4'h0);
      run(2);
      en = 1'b0;
      run(1);
      exp_q.delete();
      push_dark(3);
      run(3);

      // restart from digit 0
      en = 1'b1;
      push_dark(1);
      push_frame(16'h5678, 4'h0);
      run(25);

      // reset with a pending value discards it and clears the shadow
      push_frame(16'h5678, 4'h0);
      run(4);
      wr_valid = 1'b1; wr_data = 16'h9999;
      run(1);
      wr_valid = 1'b0;
      check("ready_pend_before_rst", 32'(wr_ready), 32'h0);
      reset = 1'b1; en = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst2_ready", 32'(wr_ready), 32'h1);
      check("rst2_an",    32'(an),       32'hF);
      check("rst2_seg",   32'(seg),      32'h7F);
      push_dark(2);
      run(2);
      en = 1'b1;
      push_dark(1);
      push_frame(16'h0000, 4'h0);
      push_frame(16'h0000, 4'h0);
      run(49);

      // small value: leading digits suppressed only with LEADING_ZERO_BLANK_EN
      en = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      wr_valid = 1'b1; wr_data = 16'h0005;
      @(negedge clk);
      wr_valid = 1'b0;
      @(negedge clk);
      check("ready_0005", 32'(wr_ready), 32'h1);
      en = 1'b1;
      push_dark(1);
      push_frame(16'h0005, 4'h0);
      run(25);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
